// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the fetch/decode/execute hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipeline_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MC_WAIT  = 2'd2
    } ctrl_state_t;

    // Default register-index width of the decode/execute register fields
    localparam int REG_AW_DEFAULT = 5;

    // Width of the load-use down-counter; covers LOAD_DELAY up to 7
    localparam int LD_CNT_W = 3;

    // Instruction word that decode/execute load when told to insert a bubble
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: one cycle from inc to the updated count.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment on each event until every bit is set, then hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multicycle freeze, branch flush.
// Latency: controls are combinational from this cycle's inputs; counters lag one cycle.
// Backpressure: pc_en/decode_en/exec_en low hold the upstream stages in place.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int REG_AW     = REG_AW_DEFAULT,
    parameter int LOAD_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_mc_start,
    input  logic              mc_done,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              decode_en,
    output logic              decode_flush,
    output logic              exec_en,
    output logic              exec_bubble,
    output logic [DWIDTH-1:0] stall_count,
    output logic [DWIDTH-1:0] flush_count
);

    ctrl_state_t         state_q, state_d;
    logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;

    logic pc_en_c, decode_en_c, decode_flush_c, exec_en_c, exec_bubble_c;
    logic flush_evt;
    logic luh;

    // A load in execute writes a register the decode instruction is about to read;
    // r0 is hardwired so never causes a dependency.
    assign luh = ex_valid && ex_is_load && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));

    // Next-state and Mealy output decode for the three sequencing states
    always_comb begin
        state_d        = state_q;
        ld_cnt_d       = ld_cnt_q;
        pc_en_c        = 1'b0;
        decode_en_c    = 1'b0;
        decode_flush_c = 1'b0;
        exec_en_c      = 1'b0;
        exec_bubble_c  = 1'b0;
        flush_evt      = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_valid && ex_branch_taken) begin
                    // Redirect fetch and squash both younger instructions
                    pc_en_c        = 1'b1;
                    decode_en_c    = 1'b1;
                    decode_flush_c = 1'b1;
                    exec_en_c      = 1'b1;
                    exec_bubble_c  = 1'b1;
                    flush_evt      = 1'b1;
                end else if (ex_valid && ex_mc_start) begin
                    // Freeze everything; the multicycle unit owns execute now
                    state_d = MC_WAIT;
                end else if (luh) begin
                    // Hold fetch/decode, let the load drain, feed bubbles behind it
                    exec_en_c     = 1'b1;
                    exec_bubble_c = 1'b1;
                    if (LOAD_DELAY > 1) begin
                        ld_cnt_d = LD_CNT_W'(LOAD_DELAY - 1);
                        state_d  = LD_STALL;
                    end
                end else begin
                    pc_en_c     = 1'b1;
                    decode_en_c = 1'b1;
                    exec_en_c   = 1'b1;
                end
            end

            LD_STALL: begin
                // Execute only sees bubbles here, so branch/mc inputs are stale
                exec_en_c     = 1'b1;
                exec_bubble_c = 1'b1;
                ld_cnt_d      = ld_cnt_q - LD_CNT_W'(1);
                if (ld_cnt_q == LD_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end

            MC_WAIT: begin
                // Resume in the same cycle the unit reports completion
                if (mc_done) begin
                    pc_en_c     = 1'b1;
                    decode_en_c = 1'b1;
                    exec_en_c   = 1'b1;
                    state_d     = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Sequencing state and load-use down-counter; reset abandons any stall in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    // Reset forces every pipeline control quiet regardless of the inputs
    assign pc_en        = rst & pc_en_c;
    assign decode_en    = rst & decode_en_c;
    assign decode_flush = rst & decode_flush_c;
    assign exec_en      = rst & exec_en_c;
    assign exec_bubble  = rst & exec_bubble_c;

    sat_counter #(
        .WIDTH (DWIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en_c),
        .count (stall_count)
    );

    sat_counter #(
        .WIDTH (DWIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_evt),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_valid, ex_is_load;
    logic       ex_mc_start, mc_done, ex_branch_taken;

    // Instance A: LOAD_DELAY=1, B: LOAD_DELAY=3, C: 4-bit counters
    logic        pc_a, de_a, df_a, ee_a, eb_a;
    logic        pc_b, de_b, df_b, ee_b, eb_b;
    logic        pc_c, de_c, df_c, ee_c, eb_c;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;
    logic [4:0]  o_a, o_b, o_c;

    assign o_a = {pc_a, de_a, df_a, ee_a, eb_a};
    assign o_b = {pc_b, de_b, df_b, ee_b, eb_b};
    assign o_c = {pc_c, de_c, df_c, ee_c, eb_c};

    // Expected {pc_en, decode_en, decode_flush, exec_en, exec_bubble}
    localparam logic [4:0] E_RUN   = 5'b11010;
    localparam logic [4:0] E_STALL = 5'b00011;
    localparam logic [4:0] E_FLUSH = 5'b11111;
    localparam logic [4:0] E_FRZ   = 5'b00000;

    pipeline_hazard_ctrl #(.DWIDTH(32), .REG_AW(5), .LOAD_DELAY(1)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
        .mc_done(mc_done), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_a), .decode_en(de_a), .decode_flush(df_a), .exec_en(ee_a),
        .exec_bubble(eb_a), .stall_count(sc_a), .flush_count(fc_a));

    pipeline_hazard_ctrl #(.DWIDTH(32), .REG_AW(5), .LOAD_DELAY(3)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
        .mc_done(mc_done), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_b), .decode_en(de_b), .decode_flush(df_b), .exec_en(ee_b),
        .exec_bubble(eb_b), .stall_count(sc_b), .flush_count(fc_b));

    pipeline_hazard_ctrl #(.DWIDTH(4), .REG_AW(5), .LOAD_DELAY(1)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
        .mc_done(mc_done), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_c), .decode_en(de_c), .decode_flush(df_c), .exec_en(ee_c),
        .exec_bubble(eb_c), .stall_count(sc_c), .flush_count(fc_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        use1, use2, valid;
        logic [4:0]  rd;
        logic        ld, mc, done, br;
        logic [4:0]  exp;
        logic [31:0] sc, fc;
    } vec_t;

    typedef struct {
        string      tag;
        logic [4:0] ea, eb, ec;
        logic [2:0] mask;
    } rec_t;

    rec_t sb_q[$];
    vec_t vecs[11];

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Push expectations at drive time, compare at the following negedge
    task automatic run_cycle(input string tag, input logic [4:0] ea, input logic [4:0] eb,
                             input logic [4:0] ec, input logic [2:0] mask);
        rec_t r;
        r.tag = tag; r.ea = ea; r.eb = eb; r.ec = ec; r.mask = mask;
        sb_q.push_back(r);
        @(negedge clk);
        r = sb_q.pop_front();
        if (r.mask[0]) cmp({r.tag, "/a"}, {27'd0, o_a}, {27'd0, r.ea});
        if (r.mask[1]) cmp({r.tag, "/b"}, {27'd0, o_b}, {27'd0, r.eb});
        if (r.mask[2]) cmp({r.tag, "/c"}, {27'd0, o_c}, {27'd0, r.ec});
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_valid = v.valid; ex_rd = v.rd; ex_is_load = v.ld;
        ex_mc_start = v.mc; mc_done = v.done; ex_branch_taken = v.br;
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; ex_valid = 0;
        ex_rd = '0; ex_is_load = 0; ex_mc_start = 0; mc_done = 0; ex_branch_taken = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rs1 rs2 u1 u2 vld rd ld mc done br exp sc fc
        vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_RUN,   32'd0, 32'd0};
        vecs[1]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0, E_STALL, 32'd1, 32'd0};
        vecs[2]  = '{5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0, 0, E_RUN,   32'd1, 32'd0};
        vecs[3]  = '{5'd0, 5'd0, 1, 0, 1, 5'd0, 1, 0, 0, 0, E_RUN,   32'd1, 32'd0};
        vecs[4]  = '{5'd3, 5'd7, 1, 0, 1, 5'd7, 1, 0, 0, 0, E_RUN,   32'd1, 32'd0};
        vecs[5]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, E_RUN,   32'd1, 32'd0};
        vecs[6]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 1, E_FLUSH, 32'd1, 32'd1};
        vecs[7]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, E_RUN,   32'd1, 32'd1};
        vecs[8]  = '{5'd0, 5'd9, 0, 1, 1, 5'd9, 1, 0, 1, 0, E_STALL, 32'd2, 32'd1};
        vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, E_RUN,   32'd2, 32'd1};
        vecs[10] = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, E_RUN,   32'd2, 32'd1};

        // Reset held with random inputs: everything quiet, counters zero
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); ex_rd = 5'($urandom);
            {id_use_rs1, id_use_rs2, ex_valid, ex_is_load} = 4'($urandom);
            {ex_mc_start, mc_done, ex_branch_taken} = 3'($urandom);
            run_cycle("reset_outs", E_FRZ, E_FRZ, E_FRZ, 3'b111);
        end
        cmp("reset_sc_a", sc_a, 32'd0);
        cmp("reset_fc_a", fc_a, 32'd0);
        cmp("reset_fc_c", {28'd0, fc_c}, 32'd0);
        set_idle();
        rst = 1'b1;
        run_cycle("release", E_RUN, E_RUN, E_RUN, 3'b111);

        // Table of single-cycle patterns on the LOAD_DELAY=1 instance
        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i]);
            run_cycle($sformatf("vec%0d", i), vecs[i].exp, E_FRZ, E_FRZ, 3'b001);
            cmp($sformatf("vec%0d_sc", i), sc_a, vecs[i].sc);
            cmp($sformatf("vec%0d_fc", i), fc_a, vecs[i].fc);
        end

        // LOAD_DELAY=3: three stall cycles, branch/mc ignored mid-stall
        do_reset();
        set_idle(); ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
        run_cycle("ld3_c0", E_STALL, E_STALL, E_FRZ, 3'b011);
        set_idle(); ex_valid = 1; ex_branch_taken = 1;
        run_cycle("ld3_c1", E_FLUSH, E_STALL, E_FRZ, 3'b011);
        set_idle(); ex_valid = 1; ex_mc_start = 1;
        run_cycle("ld3_c2", E_FRZ, E_STALL, E_FRZ, 3'b011);
        set_idle();
        run_cycle("ld3_c3", E_FRZ, E_RUN, E_FRZ, 3'b011);
        cmp("ld3_sc_b", sc_b, 32'd3);
        cmp("ld3_fc_b", fc_b, 32'd0);

        // Multicycle: same-cycle mc_done ignored, exit on mc_done in MC_WAIT
        do_reset();
        set_idle(); ex_valid = 1; ex_mc_start = 1; mc_done = 1;
        run_cycle("mc_c0", E_FRZ, E_FRZ, E_FRZ, 3'b001);
        mc_done = 0;
        run_cycle("mc_c1", E_FRZ, E_FRZ, E_FRZ, 3'b001);
        ex_branch_taken = 1; ex_is_load = 1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1;
        run_cycle("mc_c2", E_FRZ, E_FRZ, E_FRZ, 3'b001);
        ex_branch_taken = 0;
        run_cycle("mc_c3", E_FRZ, E_FRZ, E_FRZ, 3'b001);
        set_idle(); ex_valid = 1; ex_mc_start = 1; mc_done = 1;
        run_cycle("mc_c4", E_RUN, E_FRZ, E_FRZ, 3'b001);
        cmp("mc_sc_a", sc_a, 32'd4);
        cmp("mc_fc_a", fc_a, 32'd0);
        set_idle();
        run_cycle("mc_c5", E_RUN, E_FRZ, E_FRZ, 3'b001);
        cmp("mc_sc_a_hold", sc_a, 32'd4);

        // Reset mid-wait abandons MC_WAIT immediately
        set_idle(); ex_valid = 1; ex_mc_start = 1;
        run_cycle("mcr_c0", E_FRZ, E_FRZ, E_FRZ, 3'b001);
        mc_done = 1; ex_mc_start = 0;
        rst = 1'b0;
        #1;
        cmp("mcr_async_sc_a", sc_a, 32'd0);
        run_cycle("mcr_rst", E_FRZ, E_FRZ, E_FRZ, 3'b111);
        set_idle();
        rst = 1'b1;
        run_cycle("mcr_resume", E_RUN, E_RUN, E_RUN, 3'b111);
        cmp("mcr_sc_a", sc_a, 32'd0);

        // Saturation: 20 flushes on the 4-bit counter instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_idle(); ex_valid = 1; ex_branch_taken = 1;
            run_cycle($sformatf("sat%0d", i), E_FLUSH, E_FLUSH, E_FLUSH, 3'b101);
            cmp($sformatf("sat%0d_fc_c", i), {28'd0, fc_c}, (i < 15) ? i + 1 : 15);
        end
        set_idle();
        run_cycle("sat_end", E_RUN, E_RUN, E_RUN, 3'b111);
        cmp("sat_fc_c", {28'd0, fc_c}, 32'd15);
        cmp("sat_fc_a", fc_a, 32'd20);
        cmp("sat_sc_c", {28'd0, sc_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
